// File: rtl/octa_pkg.sv
// Shared types for the 16-bit core front end.
//   INST_W / PC_W : instruction and program-counter widths
//   fetch_pkt_t   : one fetched {pc, inst} pair as carried from IF to ID
package octa_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 16;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: one extra MSB beyond the address bits, so that
// equal/opposite-MSB comparisons between two pointers distinguish empty
// from full. Wraps modulo 2*DEPTH by natural overflow (DEPTH power of two).
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-low reset (pointer -> 0)
//   clr  in  synchronous clear (pointer -> 0), beats inc
//   inc  in  advance pointer by one
//   ptr  out registered pointer value, $clog2(DEPTH)+1 bits
module fifo_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH):0]   ptr
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] ptr_r;

    // pointer register: reset > clear > increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/if_id_fifo.sv
// Instruction buffer between fetch (IF) and decode (ID). Holds {pc, inst}
// packets in strict order, valid/ready on both sides, flush on taken branch.
// Handshake flags come straight from registered pointers, so there is no
// combinational path from either input side to the other.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-low reset
//   flush     in   discard all entries (and any push/pop this cycle)
//   inValid   in   IF presents a packet          inReady  out  not full
//   pcIn      in   PC of fetched instruction     instIn   in   instruction
//   outValid  out  head packet available         outReady in   ID takes head
//   pcOut     out  head PC (0 when empty)        instOut  out  head inst (0 when empty)
//   count     out  occupancy 0..DEPTH; exists only when IFQ_COUNT_EN is defined
module if_id_fifo
    import octa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] pcIn,
    input  logic [WIDTH-1:0] instIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] instOut
`ifdef IFQ_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    fetch_pkt_t    wr_pkt_s;
    fetch_pkt_t    head_s;
    fetch_pkt_t    mem_r [DEPTH];

    assign empty_s  = (wr_ptr_s == rd_ptr_s);
    assign full_s   = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) &&
                      (wr_ptr_s[AW] != rd_ptr_s[AW]);
    assign inReady  = !full_s;
    assign outValid = !empty_s;
    assign push_s   = inValid & inReady;
    assign pop_s    = outValid & outReady;

    assign wr_pkt_s.pc   = pcIn;
    assign wr_pkt_s.inst = instIn;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_s),
        .ptr (wr_ptr_s)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop_s),
        .ptr (rd_ptr_s)
    );

    // packet storage; contents are don't-care after reset/flush since pointers clear
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_s[AW-1:0]] <= wr_pkt_s;
        end
    end

    // head read, forced to zero while empty so stale entries never leak out
    always_comb begin
        head_s  = mem_r[rd_ptr_s[AW-1:0]];
        pcOut   = '0;
        instOut = '0;
        if (outValid) begin
            pcOut   = head_s.pc;
            instOut = head_s.inst;
        end else begin
            pcOut   = '0;
            instOut = '0;
        end
    end

`ifdef IFQ_COUNT_EN
    logic [PW-1:0] count_r;

    // occupancy counter, kept in lock-step with the pointer registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else if (push_s && !pop_s) begin
            count_r <= count_r + PW'(1);
        end else if (pop_s && !push_s) begin
            count_r <= count_r - PW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// Self-checking bench for if_id_fifo: directed vector table plus hand-written
// backpressure and random-handshake scoreboard sequences.
module tb_if_id_fifo;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [15:0] pcIn;
    logic [15:0] instIn;
    logic        inReady;
    logic        outValid;
    logic [15:0] pcOut;
    logic [15:0] instOut;
`ifdef IFQ_COUNT_EN
    logic [2:0]  count;
`endif

    int n_cmp;
    int n_bad;

    if_id_fifo #(.DEPTH(4), .WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .pcIn     (pcIn),
        .instIn   (instIn),
        .outValid (outValid),
        .outReady (outReady),
        .pcOut    (pcOut),
        .instOut  (instOut)
`ifdef IFQ_COUNT_EN
        ,
        .count    (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        in_valid;
        logic [15:0] pc;
        logic [15:0] inst;
        logic        out_ready;
        logic        e_ov;
        logic        e_ir;
        logic [15:0] e_pc;
        logic [15:0] e_inst;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic [15:0] pc,
                       input logic [15:0] inst, input logic orr, input logic ov, input logic ir,
                       input logic [15:0] epc, input logic [15:0] einst, input logic [2:0] ecnt);
        vecs.push_back('{r, f, iv, pc, inst, orr, ov, ir, epc, einst, ecnt});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] model_q[$];
    logic [15:0] hold_pc;
    logic [15:0] hold_inst;
    logic [15:0] next_pc;
    logic        m_push;
    logic        m_pop;
    logic [31:0] head_w;

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        pcIn     = 16'h0000;
        instIn   = 16'h0000;

        // reset held 2 cycles with inValid=1
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);
        // fill four entries, head stays at first
        add(1'b1, 1'b0, 1'b1, 16'h0000, 16'h1000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 3'd1);
        add(1'b1, 1'b0, 1'b1, 16'h0002, 16'h1002, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 3'd2);
        add(1'b1, 1'b0, 1'b1, 16'h0004, 16'h1004, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 3'd3);
        add(1'b1, 1'b0, 1'b1, 16'h0006, 16'h1006, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 3'd4);
        // 5th packet rejected while full
        add(1'b1, 1'b0, 1'b1, 16'h0008, 16'h1008, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 3'd4);
        // full + pop: pop happens, push still rejected
        add(1'b1, 1'b0, 1'b1, 16'h0008, 16'h1008, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h1002, 3'd3);
        // drain in order
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0004, 16'h1004, 3'd2);
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0006, 16'h1006, 3'd1);
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);
        // pop on empty: no change
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);
        // streaming: one in, one out, count stays 1
        add(1'b1, 1'b0, 1'b1, 16'h0010, 16'h2010, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h2010, 3'd1);
        add(1'b1, 1'b0, 1'b1, 16'h0012, 16'h2012, 1'b1, 1'b1, 1'b1, 16'h0012, 16'h2012, 3'd1);
        add(1'b1, 1'b0, 1'b1, 16'h0014, 16'h2014, 1'b1, 1'b1, 1'b1, 16'h0014, 16'h2014, 3'd1);
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);
        // three held, then push+pop with flush: everything discarded
        add(1'b1, 1'b0, 1'b1, 16'h0020, 16'h3020, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h3020, 3'd1);
        add(1'b1, 1'b0, 1'b1, 16'h0022, 16'h3022, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h3020, 3'd2);
        add(1'b1, 1'b0, 1'b1, 16'h0024, 16'h3024, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h3020, 3'd3);
        add(1'b1, 1'b1, 1'b1, 16'h0100, 16'h4100, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);
        add(1'b1, 1'b0, 1'b1, 16'h0200, 16'h5200, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h5200, 3'd1);
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);
        // reset mid-operation, with a push in the same cycle
        add(1'b1, 1'b0, 1'b1, 16'h0030, 16'h6030, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h6030, 3'd1);
        add(1'b0, 1'b0, 1'b1, 16'h0032, 16'h6032, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            flush    = vecs[i].flush;
            inValid  = vecs[i].in_valid;
            pcIn     = vecs[i].pc;
            instIn   = vecs[i].inst;
            outReady = vecs[i].out_ready;
            step();
            check($sformatf("v%0d outValid", i), {31'd0, outValid}, {31'd0, vecs[i].e_ov});
            check($sformatf("v%0d inReady", i),  {31'd0, inReady},  {31'd0, vecs[i].e_ir});
            check($sformatf("v%0d pcOut", i),    {16'd0, pcOut},    {16'd0, vecs[i].e_pc});
            check($sformatf("v%0d instOut", i),  {16'd0, instOut},  {16'd0, vecs[i].e_inst});
`ifdef IFQ_COUNT_EN
            check($sformatf("v%0d count", i),    {29'd0, count},    {29'd0, vecs[i].e_cnt});
`endif
        end

        // backpressure: head must not move while ID stalls and IF keeps pushing
        rst      = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b1;
        outReady = 1'b0;
        pcIn     = 16'h0040;
        instIn   = 16'h7040;
        step();
        for (int k = 0; k < 5; k++) begin
            pcIn   = 16'h0042 + 16'(2 * k);
            instIn = 16'h7042 + 16'(2 * k);
            step();
            check($sformatf("bp%0d outValid", k), {31'd0, outValid}, 32'd1);
            check($sformatf("bp%0d pcOut", k),    {16'd0, pcOut},    32'h0000_0040);
            check($sformatf("bp%0d instOut", k),  {16'd0, instOut},  32'h0000_7040);
        end
        check("bp full inReady", {31'd0, inReady}, 32'd0);

        // random handshakes against a queue model
        flush   = 1'b1;
        inValid = 1'b0;
        step();
        flush   = 1'b0;
        model_q.delete();
        next_pc = 16'h1000;
        for (int c = 0; c < 300; c++) begin
            inValid  = ($urandom_range(0, 99) < 60);
            outReady = ($urandom_range(0, 99) < 50);
            flush    = ($urandom_range(0, 99) < 2);
            pcIn     = next_pc;
            instIn   = ~next_pc;
            m_push   = inValid && (model_q.size() < 4);
            m_pop    = outReady && (model_q.size() > 0);
            step();
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) begin
                    model_q.push_back({next_pc, ~next_pc});
                    next_pc = next_pc + 16'd2;
                end
            end
            check($sformatf("rnd%0d outValid", c), {31'd0, outValid}, {31'd0, (model_q.size() > 0)});
            check($sformatf("rnd%0d inReady", c),  {31'd0, inReady},  {31'd0, (model_q.size() < 4)});
            head_w = (model_q.size() > 0) ? model_q[0] : 32'd0;
            check($sformatf("rnd%0d head", c), {pcOut, instOut}, head_w);
`ifdef IFQ_COUNT_EN
            check($sformatf("rnd%0d count", c), {29'd0, count}, 32'(model_q.size()));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
